// File: rtl/pet_needs_ctrl_pkg.sv
// Shared state codes, need names and helpers for the pet needs controller.
// State codes are also consumed by the face-matrix driver.
package pet_needs_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_SICK    = 4'd0,
        ST_HAPPY   = 4'd1,
        ST_NEEDY   = 4'd2,
        ST_SERVING = 4'd3
    } pet_state_t;

    typedef enum logic [2:0] {
        NEED_HUNGER = 3'd0,
        NEED_SLEEP  = 3'd1,
        NEED_PLAY   = 3'd2
    } need_t;

    localparam int MAX_NEEDS = 8;

    // Lowest-index set bit; 0 when nothing is set.
    function automatic logic [2:0] lowest_set(input logic [MAX_NEEDS-1:0] flags);
        logic [2:0] idx;
        idx = '0;
        for (int i = MAX_NEEDS - 1; i >= 0; i--) begin
            if (flags[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pet_needs_ctrl_if.sv
// Service inputs and status outputs of the pet needs controller.
// The controller side uses the slave modport.
interface pet_needs_ctrl_if #(
    parameter int NUM_NEEDS = 3,
    parameter int TW        = 12
);
    logic                 en_sensor_n;
    logic [15:0]          dist_cm;
    logic [NUM_NEEDS-1:0] act;
    logic [3:0]           state;
    logic [2:0]           need_idx;
    logic [NUM_NEEDS-1:0] need_flags;
    logic                 sensor_hold;
    logic [TW-1:0]        secs;

    modport master (
        output en_sensor_n, dist_cm, act,
        input  state, need_idx, need_flags, sensor_hold, secs
    );

    modport slave (
        input  en_sensor_n, dist_cm, act,
        output state, need_idx, need_flags, sensor_hold, secs
    );
endinterface

// File: rtl/pet_needs_ctrl_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks.
module pet_needs_ctrl_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end
endmodule

// File: rtl/pet_needs_ctrl.sv
// Multi-need pet behaviour controller: per-need age timers, raised-need flags,
// and the HAPPY/NEEDY/SERVING/SICK sequencer feeding face and 7-seg displays.
module pet_needs_ctrl
    import pet_needs_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int NUM_NEEDS = 3,
    parameter int TW        = 12,
    parameter int TIMEOUT_S = 30,
    parameter int SICK_S    = 20,
    parameter int SERVE_S   = 3,
    parameter int PROX_CM   = 5
) (
    input logic             clk,
    input logic             reset,
    pet_needs_ctrl_if.slave bus
);
    // state      | meaning
    // -----------+-----------------------------------------------------
    // ST_HAPPY   | no need raised
    // ST_NEEDY   | at least one flag set; need_idx follows lowest flag
    // ST_SERVING | need_q being served for SERVE_S seconds
    // ST_SICK    | need_q went unserved too long; only its button revives

    logic                 tick;
    pet_state_t           state_q, state_d;
    logic [2:0]           need_q;
    logic [2:0]           active_idx;
    logic [2:0]           need_cur;
    logic                 hold_q, hold_d;
    logic [TW-1:0]        secs_q;
    logic [NUM_NEEDS-1:0] act_q;
    logic [NUM_NEEDS-1:0] flags;
    logic [NUM_NEEDS-1:0] self_mask;
    logic [NUM_NEEDS-1:0] clear_mask;
    logic [NUM_NEEDS-1:0] others;
    logic [7:0]           act_edge;
    logic                 sensor_feed;
    logic                 secs_sick;
    logic                 secs_serve;
    logic                 serve_done;

    pet_needs_ctrl_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign act_edge    = 8'(bus.act & ~act_q);
    assign active_idx  = lowest_set(8'(flags));
    assign need_cur    = (state_q == ST_NEEDY) ? active_idx : need_q;
    assign sensor_feed = (need_cur == NEED_HUNGER) && !bus.en_sensor_n
                         && (bus.dist_cm <= 16'(PROX_CM));
    assign secs_sick   = (secs_q >= TW'(SICK_S));
    assign secs_serve  = (secs_q >= TW'(SERVE_S));
    assign serve_done  = (state_q == ST_SERVING) && secs_serve;
    assign self_mask   = NUM_NEEDS'(8'd1 << need_q);
    assign clear_mask  = serve_done ? self_mask : '0;
    assign others      = flags & ~self_mask;

    // A completing service clears both age and flag, overriding any tick that cycle.
    for (genvar g = 0; g < NUM_NEEDS; g++) begin : g_need
        logic [TW-1:0] age;
        logic          flag;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                age  <= '0;
                flag <= 1'b0;
            end else if (clear_mask[g]) begin
                age  <= '0;
                flag <= 1'b0;
            end else begin
                if (age >= TW'(TIMEOUT_S)) begin
                    flag <= 1'b1;
                end
                if (tick && (age != '1)) begin
                    age <= age + TW'(1);
                end
            end
        end

        assign flags[g] = flag;
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_HAPPY: begin
                if (|flags) begin
                    state_d = ST_NEEDY;
                end
            end
            ST_NEEDY: begin
                // Button beats sensor, and either beats the sick timeout.
                if (act_edge[need_cur]) begin
                    state_d = ST_SERVING;
                end else if (sensor_feed) begin
                    state_d = ST_SERVING;
                    hold_d  = 1'b1;
                end else if (secs_sick) begin
                    state_d = ST_SICK;
                end
            end
            ST_SERVING: begin
                if (secs_serve) begin
                    hold_d  = 1'b0;
                    state_d = (|others) ? ST_NEEDY : ST_HAPPY;
                end
            end
            ST_SICK: begin
                if (act_edge[need_q]) begin
                    state_d = ST_SERVING;
                end
            end
            default: begin
                state_d = ST_HAPPY;
                hold_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_HAPPY;
            need_q  <= '0;
            hold_q  <= 1'b0;
            act_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            act_q   <= bus.act;
            if (state_q == ST_NEEDY) begin
                need_q <= active_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            secs_q <= '0;
        end else if (state_d != state_q) begin
            secs_q <= '0;
        end else if (tick && (secs_q != '1)) begin
            secs_q <= secs_q + TW'(1);
        end
    end

    assign bus.state       = state_q;
    assign bus.need_idx    = need_cur;
    assign bus.need_flags  = flags;
    assign bus.sensor_hold = hold_q;
    assign bus.secs        = secs_q;

endmodule

// File: tb/tb_pet_needs_ctrl.sv
// Scenario and randomized bench for pet_needs_ctrl with a behavioural reference model.
module tb_pet_needs_ctrl;
    import pet_needs_ctrl_pkg::*;

    localparam int TICK_DIV  = 4;
    localparam int NN        = 3;
    localparam int TW        = 12;
    localparam int TIMEOUT_S = 5;
    localparam int SICK_S    = 3;
    localparam int SERVE_S   = 2;
    localparam int PROX_CM   = 5;
    localparam int SMAX      = (1 << TW) - 1;
    localparam int S_SICK = 0, S_HAPPY = 1, S_NEEDY = 2, S_SERV = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    pet_needs_ctrl_if #(.NUM_NEEDS(NN), .TW(TW)) bus();

    pet_needs_ctrl #(
        .TICK_DIV (TICK_DIV),
        .NUM_NEEDS(NN),
        .TW       (TW),
        .TIMEOUT_S(TIMEOUT_S),
        .SICK_S   (SICK_S),
        .SERVE_S  (SERVE_S),
        .PROX_CM  (PROX_CM)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: whole-number ages and seconds, evaluated once per clock.
    int            m_pre, m_st, m_secs, m_frozen;
    bit            m_hold;
    int            m_age  [NN];
    bit            m_flag [NN];
    logic [NN-1:0] m_act_prev;

    function automatic int m_lowest();
        for (int i = 0; i < NN; i++) if (m_flag[i]) return i;
        return 0;
    endfunction

    function automatic bit m_any_except(input int skip);
        for (int i = 0; i < NN; i++) if (m_flag[i] && i != skip) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NN-1:0] m_flags_vec();
        logic [NN-1:0] v;
        for (int i = 0; i < NN; i++) v[i] = m_flag[i];
        return v;
    endfunction

    function automatic int m_need();
        return (m_st == S_NEEDY) ? m_lowest() : m_frozen;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        int            cur, nst, clr;
        bit            tk;
        logic [NN-1:0] edges;
        if (reset) begin
            m_pre = 0; m_st = S_HAPPY; m_secs = 0; m_frozen = 0; m_hold = 0;
            m_act_prev = '0;
            for (int i = 0; i < NN; i++) begin m_age[i] = 0; m_flag[i] = 0; end
        end else begin
            tk    = (m_pre == TICK_DIV - 1);
            edges = bus.act & ~m_act_prev;
            cur   = m_need();
            nst   = m_st;
            clr   = -1;
            case (m_st)
                S_HAPPY: if (m_any_except(-1)) nst = S_NEEDY;
                S_NEEDY: begin
                    if (edges[cur]) nst = S_SERV;
                    else if (cur == 0 && !bus.en_sensor_n && bus.dist_cm <= PROX_CM) begin
                        nst = S_SERV; m_hold = 1;
                    end else if (m_secs >= SICK_S) nst = S_SICK;
                end
                S_SERV: begin
                    if (m_secs >= SERVE_S) begin
                        clr = m_frozen; m_hold = 0;
                        nst = m_any_except(clr) ? S_NEEDY : S_HAPPY;
                    end
                end
                default: if (edges[m_frozen]) nst = S_SERV;
            endcase
            for (int i = 0; i < NN; i++) begin
                if (i == clr) begin
                    m_age[i] = 0; m_flag[i] = 0;
                end else begin
                    if (m_age[i] >= TIMEOUT_S) m_flag[i] = 1;
                    if (tk && m_age[i] < SMAX) m_age[i] = m_age[i] + 1;
                end
            end
            if (nst != m_st) m_secs = 0;
            else if (tk && m_secs < SMAX) m_secs = m_secs + 1;
            if (m_st == S_NEEDY) m_frozen = cur;
            m_st       = nst;
            m_pre      = tk ? 0 : m_pre + 1;
            m_act_prev = bus.act;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle_inputs();
        bus.act = '0; bus.en_sensor_n = 1'b1; bus.dist_cm = 16'd200;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_leave_serving(input string name);
        int n;
        n = 0;
        while (bus.state == 4'(S_SERV) && n < 40) begin step(); n++; end
        total++;
        if (bus.state === 4'(S_SERV)) begin
            bad++; $display("FAIL %s_timeout state=%0d still serving after %0d cycles", name, bus.state, n);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        @(negedge clk);
        total++; if (bus.state !== 4'd1) begin bad++; $display("FAIL reset_state got=%0d want=1", bus.state); end
        total++; if (bus.need_flags !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", bus.need_flags); end
        total++; if (bus.sensor_hold !== 1'b0) begin bad++; $display("FAIL reset_hold got=%b want=0", bus.sensor_hold); end
        total++; if (bus.secs !== 12'd0) begin bad++; $display("FAIL reset_secs got=%0d want=0", bus.secs); end
        total++; if (bus.need_idx !== 3'd0) begin bad++; $display("FAIL reset_need got=%0d want=0", bus.need_idx); end
        reset = 1'b0;
    endtask

    task automatic test_timeout();
        step(20);
        total++; if (bus.need_flags !== 3'b000) begin bad++; $display("FAIL timeout_early flags=%b want=000", bus.need_flags); end
        step();
        total++; if (bus.need_flags !== 3'b111) begin bad++; $display("FAIL timeout_flags flags=%b want=111", bus.need_flags); end
        total++; if (bus.state !== 4'd1) begin bad++; $display("FAIL timeout_still_happy state=%0d want=1", bus.state); end
        step();
        total++; if (bus.state !== 4'd2) begin bad++; $display("FAIL timeout_needy state=%0d want=2", bus.state); end
        total++; if (bus.need_idx !== 3'd0) begin bad++; $display("FAIL timeout_need need=%0d want=0", bus.need_idx); end
    endtask

    task automatic test_sensor_feed();
        bus.en_sensor_n = 1'b0; bus.dist_cm = 16'(PROX_CM + 1);
        step();
        total++; if (bus.state !== 4'd2) begin bad++; $display("FAIL feed_too_far state=%0d want=2", bus.state); end
        bus.en_sensor_n = 1'b1; bus.dist_cm = 16'(PROX_CM);
        step();
        total++; if (bus.state !== 4'd2) begin bad++; $display("FAIL feed_disabled state=%0d want=2", bus.state); end
        bus.en_sensor_n = 1'b0; bus.dist_cm = 16'd4;
        step();
        total++; if (bus.state !== 4'd3) begin bad++; $display("FAIL feed_enter state=%0d want=3", bus.state); end
        total++; if (bus.sensor_hold !== 1'b1) begin bad++; $display("FAIL feed_hold hold=%b want=1", bus.sensor_hold); end
        idle_inputs();
        wait_leave_serving("feed");
        total++; if (bus.state !== 4'd2) begin bad++; $display("FAIL feed_exit state=%0d want=2", bus.state); end
        total++; if (bus.need_idx !== 3'd1) begin bad++; $display("FAIL feed_next_need need=%0d want=1", bus.need_idx); end
        total++; if (bus.sensor_hold !== 1'b0) begin bad++; $display("FAIL feed_hold_off hold=%b want=0", bus.sensor_hold); end
        total++; if (bus.need_flags !== 3'b110) begin bad++; $display("FAIL feed_flags flags=%b want=110", bus.need_flags); end
    endtask

    task automatic test_act_hold();
        int entries;
        logic [3:0] prev;
        bus.act = 3'b100;
        step();
        total++; if (bus.state !== 4'd2) begin bad++; $display("FAIL act_wrong_need state=%0d want=2", bus.state); end
        bus.act = 3'b000;
        step();
        entries = 0;
        prev = bus.state;
        bus.act = 3'b010;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.state == 4'd3 && prev != 4'd3) entries++;
            prev = bus.state;
        end
        bus.act = 3'b000;
        wait_leave_serving("act");
        total++; if (entries !== 1) begin bad++; $display("FAIL act_entries got=%0d want=1", entries); end
        total++; if (bus.need_flags[1] !== 1'b0) begin bad++; $display("FAIL act_flag1 got=%b want=0", bus.need_flags[1]); end
        total++; if (bus.state !== 4'(m_st)) begin bad++; $display("FAIL act_exit_state got=%0d want=%0d", bus.state, m_st); end
    endtask

    task automatic test_sick();
        int n, other;
        n = 0;
        while (bus.state != 4'd0 && n < 40) begin step(); n++; end
        total++; if (bus.state !== 4'd0) begin bad++; $display("FAIL sick_enter state=%0d want=0", bus.state); end
        total++; if (bus.need_idx !== 3'(m_frozen)) begin bad++; $display("FAIL sick_need need=%0d want=%0d", bus.need_idx, m_frozen); end
        bus.en_sensor_n = 1'b0; bus.dist_cm = 16'd0;
        step(8);
        total++; if (bus.state !== 4'd0) begin bad++; $display("FAIL sick_sensor state=%0d want=0", bus.state); end
        idle_inputs();
        other = (m_frozen + 1) % NN;
        bus.act = NN'(1 << other);
        step();
        bus.act = '0;
        step();
        total++; if (bus.state !== 4'd0) begin bad++; $display("FAIL sick_wrong_act state=%0d want=0", bus.state); end
        bus.act = NN'(1 << m_frozen);
        step();
        total++; if (bus.state !== 4'd3) begin bad++; $display("FAIL sick_revive state=%0d want=3", bus.state); end
        total++; if (bus.sensor_hold !== 1'b0) begin bad++; $display("FAIL sick_revive_hold hold=%b want=0", bus.sensor_hold); end
        bus.act = '0;
        wait_leave_serving("sick");
        total++; if (bus.need_flags !== m_flags_vec()) begin bad++; $display("FAIL sick_flags got=%b want=%b", bus.need_flags, m_flags_vec()); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        step(22);
        total++; if (bus.state !== 4'd2) begin bad++; $display("FAIL simul_pre state=%0d want=2", bus.state); end
        bus.act = 3'b001; bus.en_sensor_n = 1'b0; bus.dist_cm = 16'd2;
        step();
        total++; if (bus.state !== 4'd3) begin bad++; $display("FAIL simul_state state=%0d want=3", bus.state); end
        total++; if (bus.sensor_hold !== 1'b0) begin bad++; $display("FAIL simul_hold hold=%b want=0", bus.sensor_hold); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_serving();
        do_reset();
        step(22);
        bus.en_sensor_n = 1'b0; bus.dist_cm = 16'd4;
        step();
        total++; if (bus.sensor_hold !== 1'b1) begin bad++; $display("FAIL midrst_pre hold=%b want=1", bus.sensor_hold); end
        #2 reset = 1'b1;
        #1;
        total++; if (bus.state !== 4'd1) begin bad++; $display("FAIL midrst_state state=%0d want=1", bus.state); end
        total++; if (bus.sensor_hold !== 1'b0) begin bad++; $display("FAIL midrst_hold hold=%b want=0", bus.sensor_hold); end
        total++; if (bus.need_flags !== 3'b000) begin bad++; $display("FAIL midrst_flags flags=%b want=000", bus.need_flags); end
        total++; if (bus.secs !== 12'd0) begin bad++; $display("FAIL midrst_secs secs=%0d want=0", bus.secs); end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        step(20);
        total++; if (bus.need_flags !== 3'b000) begin bad++; $display("FAIL midrst_age_early flags=%b want=000", bus.need_flags); end
        step();
        total++; if (bus.need_flags !== 3'b111) begin bad++; $display("FAIL midrst_age_restart flags=%b want=111", bus.need_flags); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 3) == 0) bus.act = NN'($urandom_range(0, (1 << NN) - 1));
            bus.en_sensor_n = ($urandom_range(0, 2) == 0);
            bus.dist_cm = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(0, 8)) : 16'($urandom_range(9, 400));
            step();
            total++; if (bus.state !== 4'(m_st)) begin bad++; $display("FAIL rand_state c=%0d got=%0d want=%0d", c, bus.state, m_st); end
            total++; if (bus.need_flags !== m_flags_vec()) begin bad++; $display("FAIL rand_flags c=%0d got=%b want=%b", c, bus.need_flags, m_flags_vec()); end
            total++; if (bus.sensor_hold !== m_hold) begin bad++; $display("FAIL rand_hold c=%0d got=%b want=%b", c, bus.sensor_hold, m_hold); end
            total++; if (bus.secs !== TW'(m_secs)) begin bad++; $display("FAIL rand_secs c=%0d got=%0d want=%0d", c, bus.secs, m_secs); end
            if (m_st != S_HAPPY) begin
                total++; if (bus.need_idx !== 3'(m_need())) begin bad++; $display("FAIL rand_need c=%0d got=%0d want=%0d", c, bus.need_idx, m_need()); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_timeout();
        test_sensor_feed();
        test_act_hold();
        test_sick();
        test_simultaneous();
        test_reset_mid_serving();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
